// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : Shift-and-add sequencer for a 16x16 unsigned multiply whose
//               product is truncated to WIDTH bits. It has no adder of its
//               own. It drives the operands of the shared Add datapath and
//               captures the sum that comes back.
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous active-high reset
//               start    - multiply request, sampled only in IDLE
//               a, b     - multiplicand / multiplier, captured on accepted start
//               add_sum  - sum from the shared adder (combinational of add_a/b)
//               add_a/b  - adder operands, zero outside RUN
//               product  - accumulator, final once done pulses
//               busy     - high while in RUN
//               done     - one-cycle pulse when product is final
//               ovf      - sticky: true product did not fit in WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] add_sum,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic [WIDTH-1:0] product,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             r_ovf;

  logic [WIDTH-1:0] w_mplier_shr;
  logic             w_last;
  logic             w_carry;
  logic             w_lost_bit;

  // RUN ends once no set multiplier bits remain after this cycle's shift.
  assign w_mplier_shr = r_mplier >> 1;
  assign w_last       = (w_mplier_shr == '0);

  // A wrapped sum is smaller than the accumulator it started from.
  assign w_carry      = r_mplier[0] && (add_sum < r_acc);

  // Shifting out a multiplicand '1' matters only if a later multiplier bit
  // could still add it. On the final cycle nothing more is added, so the
  // bit lost there does not indicate overflow.
  assign w_lost_bit   = r_mcand[WIDTH-1] && !w_last;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    add_a        = '0;
    add_b        = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        add_a = r_acc;
        add_b = r_mcand;
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) begin
            r_acc <= add_sum;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_shr;
          if (w_carry || w_lost_bit) begin
            r_ovf <= 1'b1;
          end
        end
        default: begin
          // DONE: hold the result
        end
      endcase
    end
  end

  assign product = r_acc;
  assign ovf     = r_ovf;

endmodule
`default_nettype wire
